uart_result_tx: RTL and testbench

UART_RESULT_TX -- requirements
Module: uart_result_tx

---
 rtl/uart_result_tx.sv | 124 ++++++++++++
 tb/tb_uart_result_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_result_tx.sv
// Serialises a 13-byte {ack, a, b, result} response frame onto a UART line.
// 8N1 framing, MSB byte of each word first, data bits LSB first.
module uart_result_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  ack_code,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        FINISH
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_BYTE = 4'(NUM_BYTES - 1);

    state_t       state;
    logic [15:0]  baud_cnt;
    logic [2:0]   bit_idx;
    logic [3:0]   byte_idx;
    logic [101:0] payload;

    logic [103:0] frame;
    logic [3:0]   byte_rev;
    logic [7:0]   cur_byte;
    logic [2:0]   next_bit;
    logic         bit_end;

    // Byte 0 lives in the top of the frame word, so index from the top.
    assign frame    = {2'b00, payload};
    assign byte_rev = LAST_BYTE - byte_idx;
    assign cur_byte = frame[{byte_rev, 3'b000} +: 8];
    assign next_bit = bit_idx + 3'd1;
    assign bit_end  = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            payload  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        payload  <= {ack_code, a, b, result};
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= cur_byte[0];
                        state    <= DATA_BITS;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA_BITS: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP_BIT;
                        end else begin
                            bit_idx <= next_bit;
                            tx      <= cur_byte[next_bit];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP_BIT: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (byte_idx < LAST_BYTE) begin
                            byte_idx <= byte_idx + 4'd1;
                            tx       <= 1'b0;
                            state    <= START_BIT;
                        end else begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx: cycle-level tx/busy/done model plus a UART
// decoder whose bytes are matched against an expected-byte queue.
module tb_uart_result_tx;

    localparam int CPB   = 4;
    localparam int NB    = 13;
    localparam int FRAME = NB * 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  ack_code = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result = '0;
    logic        busy;
    logic        done;
    logic        tx;

    uart_result_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_BYTES(NB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ack_code(ack_code),
        .a(a),
        .b(b),
        .result(result),
        .busy(busy),
        .done(done),
        .tx(tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: edge number of the accepted start and its bytes
    bit         have_frame = 1'b0;
    int         fe = 0;
    int         next_ok = 0;
    logic [7:0] fb[NB];
    logic [7:0] exp_q[$];

    bit         dec_act = 1'b0;
    int         dcnt = 0;
    logic [7:0] dbyte = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] frame_byte(input logic [5:0] ac,
        input logic [31:0] aa, input logic [31:0] bb,
        input logic [31:0] rr, input int k);
        logic [31:0] w;
        int sh;
        if (k == 0) return {2'b00, ac};
        w  = (k <= 4) ? aa : (k <= 8) ? bb : rr;
        sh = (3 - ((k - 1) % 4)) * 8;
        return 8'(w >> sh);
    endfunction

    function automatic logic exp_tx(input int c);
        int off, bp, byt, pos;
        if (!have_frame || c < fe || c > fe + FRAME - 1) return 1'b1;
        off = c - fe;
        bp  = off / CPB;
        byt = bp / 10;
        pos = bp % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return fb[byt][pos-1];
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            have_frame = 1'b0;
            exp_q.delete();
            dec_act = 1'b0;
            next_ok = cyc + 1;
        end else begin
            check("tx", tx, exp_tx(cyc));
            check("busy", busy,
                  have_frame && cyc >= fe && cyc <= fe + FRAME - 1);
            check("done", done, have_frame && cyc == fe + FRAME);

            if (dec_act) dcnt++;
            else if (tx == 1'b0) begin
                dec_act = 1'b1;
                dcnt = 0;
                dbyte = '0;
            end
            if (dec_act && dcnt == 2) check("start_bit", tx, 0);
            if (dec_act && dcnt >= 6 && dcnt <= 34 && dcnt % 4 == 2)
                dbyte[(dcnt-6)/4] = tx;
            if (dec_act && dcnt == 38) begin
                check("stop_bit", tx, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL byte at cycle %0d: got %h, none expected",
                             cyc, dbyte);
                end else begin
                    check("byte", dbyte, exp_q.pop_front());
                end
                dec_act = 1'b0;
            end

            if (start && cyc + 1 >= next_ok) begin
                fe = cyc + 1;
                have_frame = 1'b1;
                for (int k = 0; k < NB; k++) begin
                    fb[k] = frame_byte(ack_code, a, b, result, k);
                    exp_q.push_back(fb[k]);
                end
                next_ok = fe + FRAME + 2;
            end
        end
    end

    task automatic scramble();
        ack_code = 6'($urandom);
        a = $urandom;
        b = $urandom;
        result = $urandom;
    endtask

    task automatic pulse();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        ack_code = 6'h01;
        a = 32'h3F800000;
        b = 32'h40000000;
        result = 32'h40400000;
        pulse();
        @(posedge clk);
        #1 scramble();
        repeat (97) @(posedge clk);
        #1 pulse();
        repeat (420) @(posedge clk);
        #1 pulse();
        repeat (10) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            #1 scramble();
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1 pulse();
            for (int c = 0; c < 530; c++) begin
                @(posedge clk);
                #1 scramble();
                start = ($urandom_range(0, 99) == 0);
            end
            start = 1'b0;
            repeat (530) @(posedge clk);
        end

        #1 scramble();
        pulse();
        repeat (199) @(posedge clk);
        #1 reset = 1'b1;
        #1 check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        scramble();
        pulse();
        repeat (530) @(posedge clk);

        #1 start = 1'b1;
        for (int c = 0; c < 1100; c++) begin
            @(posedge clk);
            #1 scramble();
        end
        start = 1'b0;
        repeat (560) @(posedge clk);

        #1 check("exp_q_empty", exp_q.size(), 0);
        check("decoder_idle", dec_act, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
